// File: rtl/key_event_encoder_pkg.sv
// Shared constants and types for the key event encoder: key/code widths,
// event word layout, default repeat timing and the repeat FSM states.
package key_event_encoder_pkg;

  localparam int N_KEYS_DEF       = 9;
  localparam int CODE_W_DEF       = 4;
  localparam int EV_W_DEF         = CODE_W_DEF + 1;
  localparam int REPEAT_BIT_DEF   = CODE_W_DEF;
  localparam int FIFO_DEPTH_DEF   = 4;
  localparam int REPEAT_DELAY_DEF = 50_000_000;
  localparam int REPEAT_RATE_DEF  = 10_000_000;
  localparam int RPT_CNT_W        = 32;

  typedef enum logic [1:0] {
    RPT_IDLE  = 2'd0,
    RPT_DELAY = 2'd1,
    RPT_RATE  = 2'd2
  } rpt_state_e;

endpackage

// File: rtl/key_event_encoder_event_fifo.sv
// Show-ahead synchronous FIFO; a push while full is taken only when a pop
// frees the head slot in the same cycle.
module event_fifo #(
  parameter  int WIDTH = 5,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [AW-1:0]               wr_q, rd_q;
  logic [AW:0]                 cnt_q;
  logic                        do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = mem_q[rd_q];
  assign count_o = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= wdata_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/key_event_encoder.sv
// Turns debounced key levels into press / auto-repeat events, one push per
// cycle (lowest pending key first, then a due repeat), buffered in a FIFO.
module key_event_encoder
  import key_event_encoder_pkg::*;
#(
  parameter int N_KEYS       = N_KEYS_DEF,
  parameter int CODE_W       = CODE_W_DEF,
  parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF,
  parameter int REPEAT_DELAY = REPEAT_DELAY_DEF,
  parameter int REPEAT_RATE  = REPEAT_RATE_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_KEYS-1:0] debounced,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic [CODE_W-1:0] ev_code,
  output logic              ev_repeat,
  output logic              overflow,
  input  logic              overflow_clr
);

  localparam int EV_W  = CODE_W + 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [RPT_CNT_W-1:0] DELAY_LAST = RPT_CNT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_CNT_W-1:0] RATE_LAST  = RPT_CNT_W'(REPEAT_RATE - 1);

  logic [N_KEYS-1:0]    prev_q, pending_q, pending_d, rise, served;
  logic [RPT_CNT_W-1:0] cnt_q;
  rpt_state_e           rpt_q;
  logic                 rpt_req_q, rpt_take;
  logic                 overflow_q, overflow_d;
  logic                 held_one, held_chg, any_pending;
  logic [CODE_W-1:0]    pend_code, held_code;
  logic                 push, pop, drop;
  logic [EV_W-1:0]      push_word, head_word;
  logic                 fifo_full, fifo_empty;
  logic [CNT_W-1:0]     fifo_count;

  assign rise        = debounced & ~prev_q;
  assign held_chg    = (debounced != prev_q);
  assign held_one    = (debounced != '0) && ((debounced & (debounced - 1'b1)) == '0);
  assign any_pending = (pending_q != '0);
  assign served      = pending_q & (~pending_q + 1'b1);

  // Repeat code comes from prev_q: it is the held set the request was raised for.
  always_comb begin
    pend_code = '0;
    held_code = '0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (pending_q[i]) pend_code = CODE_W'(i);
      if (prev_q[i])    held_code = CODE_W'(i);
    end
  end

  assign rpt_take  = ~any_pending & rpt_req_q & ~held_chg;
  assign push      = any_pending | rpt_take;
  assign push_word = any_pending ? {1'b0, pend_code} : {1'b1, held_code};
  assign pop       = ev_ready & ~fifo_empty;
  assign drop      = push & fifo_full & ~pop;

  assign pending_d  = (pending_q | rise) & ~served;
  assign overflow_d = drop ? 1'b1 : (overflow_clr ? 1'b0 : overflow_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q     <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      prev_q     <= debounced;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  // Repeat timer: any change of the held set, or anything but a sole key, restarts it.
  // A new request raised in the same cycle one is pushed wins over the clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rpt_q     <= RPT_IDLE;
      cnt_q     <= '0;
      rpt_req_q <= 1'b0;
    end else if (held_chg || !held_one) begin
      rpt_q     <= RPT_IDLE;
      cnt_q     <= '0;
      rpt_req_q <= 1'b0;
    end else begin
      if (rpt_take) rpt_req_q <= 1'b0;
      case (rpt_q)
        RPT_RATE: begin
          if (cnt_q == RATE_LAST) begin
            cnt_q     <= '0;
            rpt_req_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          if (cnt_q == DELAY_LAST) begin
            cnt_q     <= '0;
            rpt_req_q <= 1'b1;
            rpt_q     <= RPT_RATE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            rpt_q <= RPT_DELAY;
          end
        end
      endcase
    end
  end

  event_fifo #(
    .WIDTH (EV_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (push),
    .wdata_i (push_word),
    .pop_i   (pop),
    .rdata_o (head_word),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign ev_valid  = (fifo_count != '0);
  assign ev_code   = ev_valid ? head_word[CODE_W-1:0] : '0;
  assign ev_repeat = ev_valid & head_word[CODE_W];
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_key_event_encoder.sv
// Bench for key_event_encoder: scoreboard of expected {repeat,code} words
// consumed on every accepted handshake, a vector table plus corner sequences.
module tb_key_event_encoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] debounced;
  logic       ev_valid, ev_ready, ev_repeat, overflow, overflow_clr;
  logic [3:0] ev_code;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int evt_cnt  = 0;
  int sb[$];
  int pop_cyc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  key_event_encoder #(
    .REPEAT_DELAY (20),
    .REPEAT_RATE  (5)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .debounced    (debounced),
    .ev_valid     (ev_valid),
    .ev_ready     (ev_ready),
    .ev_code      (ev_code),
    .ev_repeat    (ev_repeat),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: every accepted handshake must match the oldest expected word.
  always @(negedge clk) begin
    if (reset && ev_valid && ev_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event: got rpt=%0d code=%0d expected none", ev_repeat, ev_code);
      end else begin
        chk("event_word", 32'({ev_repeat, ev_code}), sb.pop_front());
      end
      evt_cnt++;
      pop_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_keys(input logic [8:0] keys);
    for (int k = 0; k < 9; k++) if (keys[k]) sb.push_back(k);
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (sb.size() == 0) break;
      tick();
    end
    chk({"drain_", name}, sb.size(), 0);
    repeat (2) tick();
  endtask

  typedef struct {
    logic [8:0] keys;
    int         hold;
    int         n_ev;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    vecs[0] = '{9'h008, 3,  1};
    vecs[1] = '{9'h121, 6,  3};
    vecs[2] = '{9'h1FF, 12, 9};
    vecs[3] = '{9'h100, 1,  1};
    vecs[4] = '{9'h006, 1,  2};
    vecs[5] = '{9'h001, 2,  1};

    reset = 1'b0; debounced = '0; ev_ready = 1'b0; overflow_clr = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(ev_valid), 0);
    chk("rst_code", 32'(ev_code), 0);
    chk("rst_repeat", 32'(ev_repeat), 0);
    chk("rst_overflow", 32'(overflow), 0);
    tick();
    reset = 1'b1;
    repeat (2) tick();

    // Single key 3: latency and exactly one event
    base = evt_cnt;
    ev_ready = 1'b1;
    sb.push_back(3);
    debounced = 9'h008;
    @(negedge clk);
    chk("t1_valid_e0", 32'(ev_valid), 0);
    @(negedge clk);
    chk("t1_valid_e1", 32'(ev_valid), 0);
    @(negedge clk);
    chk("t1_valid_e2", 32'(ev_valid), 1);
    chk("t1_code", 32'(ev_code), 3);
    chk("t1_repeat", 32'(ev_repeat), 0);
    tick();
    debounced = '0;
    wait_drain("t1", 20);
    chk("t1_count", evt_cnt - base, 1);

    // Table of press patterns, consumer always ready
    foreach (vecs[v]) begin
      base = evt_cnt;
      expect_keys(vecs[v].keys);
      debounced = vecs[v].keys;
      repeat (vecs[v].hold) tick();
      debounced = '0;
      wait_drain("vec", 30);
      chk("vec_count", evt_cnt - base, vecs[v].n_ev);
    end

    // Keys 0,5,8 at once, consumer stalled, then drained in index order
    ev_ready = 1'b0;
    expect_keys(9'h121);
    debounced = 9'h121;
    repeat (6) tick();
    @(negedge clk);
    chk("t2_valid_held", 32'(ev_valid), 1);
    chk("t2_head", 32'(ev_code), 0);
    tick();
    ev_ready = 1'b1;
    wait_drain("t2", 20);
    @(negedge clk);
    chk("t2_valid_empty", 32'(ev_valid), 0);
    chk("t2_code_empty", 32'(ev_code), 0);
    tick();
    debounced = '0;
    repeat (3) tick();

    // Sole held key auto-repeats: 20 cycles to first repeat, then every 5
    base = evt_cnt;
    pop_cyc.delete();
    sb.push_back(2);
    for (int r = 0; r < 4; r++) sb.push_back(16 + 2);
    sb.push_back(6);
    debounced = 9'h004;
    repeat (38) tick();
    debounced = 9'h044;
    repeat (30) tick();
    debounced = '0;
    wait_drain("t3", 20);
    chk("t3_count", evt_cnt - base, 6);
    if (pop_cyc.size() >= 5) begin
      chk("t3_first_gap", pop_cyc[1] - pop_cyc[0], 20);
      for (int r = 2; r < 5; r++) chk("t3_rate_gap", pop_cyc[r] - pop_cyc[r-1], 5);
    end else begin
      checks++;
      failures++;
      $display("FAIL t3_gaps: got %0d pops expected at least 5", pop_cyc.size());
    end

    // Overflow: six presses into a 4-deep FIFO with no consumer
    ev_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k < 4) sb.push_back(k);
      debounced = 9'(1 << k);
      tick();
      debounced = '0;
      tick();
    end
    repeat (3) tick();
    @(negedge clk);
    chk("t4_overflow_set", 32'(overflow), 1);
    chk("t4_head", 32'(ev_code), 0);
    tick();
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    @(negedge clk);
    chk("t4_overflow_clr", 32'(overflow), 0);
    tick();
    // push and pop together while full: accepted, no overflow
    sb.push_back(6);
    debounced = 9'h040;
    tick();
    debounced = '0;
    ev_ready = 1'b1;
    tick();
    ev_ready = 1'b0;
    @(negedge clk);
    chk("t4_full_pushpop_ovf", 32'(overflow), 0);
    chk("t4_full_pushpop_head", 32'(ev_code), 1);
    tick();
    ev_ready = 1'b1;
    wait_drain("t4", 20);
    @(negedge clk);
    chk("t4_empty", 32'(ev_valid), 0);
    tick();

    // Reset with queued and pending events; held keys re-report after release
    ev_ready = 1'b0;
    debounced = 9'h09F;
    repeat (4) tick();
    @(negedge clk);
    chk("t5_pre_valid", 32'(ev_valid), 1);
    tick();
    reset = 1'b0;
    sb.delete();
    #1;
    chk("t5_rst_valid", 32'(ev_valid), 0);
    chk("t5_rst_code", 32'(ev_code), 0);
    chk("t5_rst_repeat", 32'(ev_repeat), 0);
    chk("t5_rst_overflow", 32'(overflow), 0);
    repeat (2) tick();
    base = evt_cnt;
    ev_ready = 1'b1;
    expect_keys(9'h09F);
    reset = 1'b1;
    wait_drain("t5", 30);
    chk("t5_count", evt_cnt - base, 6);
    debounced = '0;
    repeat (3) tick();
    @(negedge clk);
    chk("final_valid", 32'(ev_valid), 0);
    chk("final_sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
